pc_flag_unit: RTL and testbench
===============================

# pc_flag_unit

Program-counter and flag-register stage directly downstream of the 32-bit ALU in the KGP_RISC datapath. It latches the ALU's zero/carry/sign/overflow flags, evaluates branch conditions against those flags or the ALU result, and advances or redirects the PC. It also raises a one-cycle flush so fetch discards the wrong-path instruction after a taken branch, and produces the link address for calls.

## Interface
- `PC_WIDTH`, 32, width of PC, targets and ALU result
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  stage enable; 0 = stall, all state holds
- `flags_we`  in  1  capture incoming ALU flags this cycle
- `zero_flag_in`, `carry_flag_in`, `sign_flag_in`, `overflow_flag_in`  in  1 each  ALU flag outputs
- `alu_result`  in  PC_WIDTH  ALU result, used as a register operand or target
- `br_valid`  in  1  a branch/jump instruction is present
- `br_cond`  in  4  condition code, see Operation
- `br_target`  in  PC_WIDTH  immediate absolute target
- `pc`  out  PC_WIDTH  current PC, registered
- `flags`  out  4  registered {Z,C,S,V}
- `branch_taken`  out  1  registered pulse: redirect happened last edge
- `flush`  out  1  registered; fetch discards its instruction
- `link_valid`  out  1  registered pulse on a taken call
- `link_addr`  out  PC_WIDTH  registered old PC+4, valid with `link_valid`

## Operation
- Condition codes:
  - 0000 never
  - 0001 b (always, `br_target`)
  - 0010 br (always, target = `alu_result`)
  - 0011 bltz (`alu_result[31]`)
  - 0100 bz (`alu_result==0`)
  - 0101 bnz
  - 0110 bcy (C)
  - 0111 bncy
  - 1000 bs (S)
  - 1001 bns
  - 1010 bv (V)
  - 1011 bnv
  - 1100 call (always, `br_target`, link)
  - 1101–1111 reserved, treated as never.
- Flag source: if `flags_we`=1 in the same cycle, conditions use the incoming flags (forwarding). Otherwise they use the registered `flags`.
- FSM:
  - RUN:
    - If `en`=1 and a taken branch occurs, PC←target and go to FLUSH.
    - Otherwise, if `en`=1, PC←PC+4.
  - FLUSH (one cycle):
    - `flush`=1.
    - `br_valid` is ignored (wrong-path slot).
    - If `en`=1, PC←PC+4 and go to RUN.
    - If `en`=0, hold FLUSH and keep `flush`=1.
- `flags_we` is honoured in FLUSH only when the instruction is not from the discarded slot. Fetch guarantees `flags_we`=0 during flush.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFFFFFFFC+4 wraps to 0. Targets are used unmodified; no alignment checking.
- `en`=0: PC, flags, state and all registered outputs hold. Pulses (`branch_taken`, `link_valid`) deassert after one cycle even while stalled.
- call: `link_addr`←PC+4 (pre-branch PC), `link_valid`=1 for one cycle.

## Timing
- Reset (`rst`=1 at an edge):
  - `pc`=RESET_PC
  - `flags`=0000
  - `branch_taken`=0, `flush`=0, `link_valid`=0, `link_addr`=0
  - state RUN.
  - Reset overrides `en`, `flags_we` and `br_valid`, including mid-FLUSH.
- Branch latency: decision in cycle N, new `pc` and `branch_taken`=1 / `flush`=1 visible after edge N+1.
- Flag capture: visible on `flags` one edge after `flags_we`.
- No combinational path from inputs to any output.

## Structure
- Package `kgp_branch_pkg`: the 4-bit condition-code localparams, flag bit indices (Z=3,C=2,S=1,V=0), FSM state encoding.
- One combinational sub-module `branch_cond_eval` (cond, flags, alu_result → taken, target_sel). The top module holds registers and the FSM.

## Test plan
- Reset with RESET_PC=0, then `en`=1 for 3 cycles → `pc` 0,4,8,12; `flags`=0000.
- `flags_we`=1 with C=1; next cycle bcy (0110) with `br_target`=0x40 → `pc`=0x40, `branch_taken`=1, `flush`=1 for one cycle, then `pc`=0x44.
- Same cycle: `flags_we`=1 with Z=0, V=1 and bnv (1011) → not taken (forwarded V), `pc`=+4.
- bz with `alu_result`=0, then bnz with `alu_result`=5, target 0x100 → both taken. A `br_valid` b to 0x200 during the FLUSH cycle is ignored.
- call (1100) at `pc`=0x20, target 0x80 → `pc`=0x80, `link_valid`=1, `link_addr`=0x24. With `en`=0 held for 2 cycles in FLUSH → `pc` holds and `flush` stays 1.
- `rst` asserted during FLUSH → next edge `pc`=RESET_PC, `flush`=0. Separately, `pc`=0xFFFFFFFC plus one step → `pc`=0.

Source files
------------

// File: rtl/pc_flag_unit_pkg.sv
// Shared definitions for the PC/flag stage: branch condition codes, flag bit
// positions inside the {Z,C,S,V} flag word, FSM state and branch target select.
package kgp_branch_pkg;

  localparam logic [3:0] CC_NEVER = 4'b0000;
  localparam logic [3:0] CC_B     = 4'b0001;
  localparam logic [3:0] CC_BR    = 4'b0010;
  localparam logic [3:0] CC_BLTZ  = 4'b0011;
  localparam logic [3:0] CC_BZ    = 4'b0100;
  localparam logic [3:0] CC_BNZ   = 4'b0101;
  localparam logic [3:0] CC_BCY   = 4'b0110;
  localparam logic [3:0] CC_BNCY  = 4'b0111;
  localparam logic [3:0] CC_BS    = 4'b1000;
  localparam logic [3:0] CC_BNS   = 4'b1001;
  localparam logic [3:0] CC_BV    = 4'b1010;
  localparam logic [3:0] CC_BNV   = 4'b1011;
  localparam logic [3:0] CC_CALL  = 4'b1100;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef enum logic {
    TGT_IMM = 1'b0,
    TGT_ALU = 1'b1
  } target_sel_t;

endpackage

// File: rtl/pc_flag_unit_if.sv
// Bundle between the PC/flag stage and its neighbours (ALU, decode, fetch).
//   slave  : the pc_flag_unit side (consumes ALU/branch inputs, drives pc/flags/etc.)
//   master : the surrounding datapath / testbench side
interface pc_flag_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                en;
  logic                flags_we;
  logic                zero_flag_in;
  logic                carry_flag_in;
  logic                sign_flag_in;
  logic                overflow_flag_in;
  logic [PC_WIDTH-1:0] alu_result;
  logic                br_valid;
  logic [3:0]          br_cond;
  logic [PC_WIDTH-1:0] br_target;

  logic [PC_WIDTH-1:0] pc;
  logic [3:0]          flags;
  logic                branch_taken;
  logic                flush;
  logic                link_valid;
  logic [PC_WIDTH-1:0] link_addr;

  modport master (
    output en, flags_we, zero_flag_in, carry_flag_in, sign_flag_in,
           overflow_flag_in, alu_result, br_valid, br_cond, br_target,
    input  pc, flags, branch_taken, flush, link_valid, link_addr
  );

  modport slave (
    input  en, flags_we, zero_flag_in, carry_flag_in, sign_flag_in,
           overflow_flag_in, alu_result, br_valid, br_cond, br_target,
    output pc, flags, branch_taken, flush, link_valid, link_addr
  );
endinterface

// File: rtl/pc_flag_unit_cond.sv
// branch_cond_eval: purely combinational branch condition evaluation.
//   i_cond       : 4-bit condition code
//   i_flags      : effective {Z,C,S,V} (already forwarded if applicable)
//   i_alu_result : ALU result, tested directly by bltz/bz/bnz
//   o_taken      : condition holds (br_valid gating is done by the caller)
//   o_target_sel : TGT_ALU for register-indirect br, TGT_IMM otherwise
module branch_cond_eval
  import kgp_branch_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   i_cond,
  input  logic [3:0]   i_flags,
  input  logic [W-1:0] i_alu_result,
  output logic         o_taken,
  output target_sel_t  o_target_sel
);

  always_comb begin
    o_taken      = 1'b0;
    o_target_sel = TGT_IMM;
    case (i_cond)
      CC_B:    o_taken = 1'b1;
      CC_BR: begin
        o_taken      = 1'b1;
        o_target_sel = TGT_ALU;
      end
      CC_BLTZ: o_taken = i_alu_result[W-1];
      CC_BZ:   o_taken = (i_alu_result == '0);
      CC_BNZ:  o_taken = (i_alu_result != '0);
      CC_BCY:  o_taken = i_flags[FLAG_C];
      CC_BNCY: o_taken = ~i_flags[FLAG_C];
      CC_BS:   o_taken = i_flags[FLAG_S];
      CC_BNS:  o_taken = ~i_flags[FLAG_S];
      CC_BV:   o_taken = i_flags[FLAG_V];
      CC_BNV:  o_taken = ~i_flags[FLAG_V];
      CC_CALL: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_flag_unit.sv
// pc_flag_unit: PC and flag register stage behind the ALU. Latches ALU flags,
// resolves branches, redirects the PC and raises a one-cycle flush so fetch
// drops the wrong-path instruction. Calls also produce a link address.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pc_flag_unit_if.slave (stall/flag/branch inputs; pc, flags,
//              branch_taken, flush, link_valid, link_addr outputs, all registered)
//
// state    | meaning
// ST_RUN   | normal sequencing, branches are evaluated
// ST_FLUSH | wrong-path slot after a taken branch; br_valid ignored
module pc_flag_unit
  import kgp_branch_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  pc_flag_unit_if.slave bus
);

  state_t              r_state, w_state_next;
  logic [PC_WIDTH-1:0] r_pc, w_pc_next, w_pc_plus4, w_target;
  logic [PC_WIDTH-1:0] r_link_addr;
  logic [3:0]          r_flags, w_flags_in, w_flags_eff;
  logic                r_branch_taken, r_flush, r_link_valid;
  logic                w_cond_taken, w_take, w_is_call;
  target_sel_t         w_target_sel;

  assign w_flags_in  = {bus.zero_flag_in, bus.carry_flag_in,
                        bus.sign_flag_in, bus.overflow_flag_in};
  // Forward the incoming flags so a compare and its branch can share a cycle.
  assign w_flags_eff = bus.flags_we ? w_flags_in : r_flags;
  assign w_pc_plus4  = r_pc + PC_WIDTH'(4);
  assign w_is_call   = (bus.br_cond == CC_CALL);

  branch_cond_eval #(.W(PC_WIDTH)) u_cond (
    .i_cond       (bus.br_cond),
    .i_flags      (w_flags_eff),
    .i_alu_result (bus.alu_result),
    .o_taken      (w_cond_taken),
    .o_target_sel (w_target_sel)
  );

  assign w_target = (w_target_sel == TGT_ALU) ? bus.alu_result : bus.br_target;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_take       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.en) begin
          if (bus.br_valid && w_cond_taken) begin
            w_take       = 1'b1;
            w_pc_next    = w_target;
            w_state_next = ST_FLUSH;
          end else begin
            w_pc_next = w_pc_plus4;
          end
        end
      end
      ST_FLUSH: begin
        if (bus.en) begin
          w_pc_next    = w_pc_plus4;
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_flags        <= 4'b0000;
      r_branch_taken <= 1'b0;
      r_flush        <= 1'b0;
      r_link_valid   <= 1'b0;
      r_link_addr    <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (bus.en && bus.flags_we) r_flags <= w_flags_in;
      // Pulses drop after one cycle even during a stall.
      r_branch_taken <= w_take;
      r_link_valid   <= w_take && w_is_call;
      if (w_take && w_is_call) r_link_addr <= w_pc_plus4;
      // Tracks the state so flush stays high while FLUSH is stalled.
      r_flush <= (w_state_next == ST_FLUSH);
    end
  end

  assign bus.pc           = r_pc;
  assign bus.flags        = r_flags;
  assign bus.branch_taken = r_branch_taken;
  assign bus.flush        = r_flush;
  assign bus.link_valid   = r_link_valid;
  assign bus.link_addr    = r_link_addr;

endmodule

// File: tb/tb_pc_flag_unit.sv
// Directed testbench for pc_flag_unit with hand-computed expected values.
module tb_pc_flag_unit;
  import kgp_branch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  pc_flag_unit_if #(.PC_WIDTH(32)) bus ();

  pc_flag_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] pc, input logic bt, input logic fl);
    chk({tag, ".pc"},    bus.pc,           pc);
    chk({tag, ".taken"}, bus.branch_taken, {31'b0, bt});
    chk({tag, ".flush"}, bus.flush,        {31'b0, fl});
  endtask

  task automatic br(input logic [3:0] cc, input logic [31:0] tgt, input logic [31:0] alu);
    bus.br_valid   = 1'b1;
    bus.br_cond    = cc;
    bus.br_target  = tgt;
    bus.alu_result = alu;
  endtask

  task automatic nobr();
    bus.br_valid   = 1'b0;
    bus.br_cond    = CC_NEVER;
    bus.br_target  = 32'h0;
    bus.alu_result = 32'h0;
  endtask

  task automatic fl(input logic we, input logic [3:0] f);
    bus.flags_we         = we;
    bus.zero_flag_in     = f[3];
    bus.carry_flag_in    = f[2];
    bus.sign_flag_in     = f[1];
    bus.overflow_flag_in = f[0];
  endtask

  initial begin
    rst    = 1'b1;
    bus.en = 1'b0;
    nobr();
    fl(1'b0, 4'b0000);
    step();
    chk_pc("reset", 32'h0, 1'b0, 1'b0);
    chk("reset.flags", bus.flags, 32'h0);
    chk("reset.lv", bus.link_valid, 32'h0);
    chk("reset.la", bus.link_addr, 32'h0);

    rst    = 1'b0;
    bus.en = 1'b1;
    step(); chk_pc("run1", 32'h4, 1'b0, 1'b0);
    step(); chk_pc("run2", 32'h8, 1'b0, 1'b0);
    step(); chk_pc("run3", 32'hC, 1'b0, 1'b0);
    chk("run3.flags", bus.flags, 32'h0);

    fl(1'b1, 4'b0100);
    step(); chk_pc("capC", 32'h10, 1'b0, 1'b0);
    chk("capC.flags", bus.flags, 32'h4);

    fl(1'b0, 4'b0000);
    br(CC_BCY, 32'h40, 32'h0);
    step(); chk_pc("bcy", 32'h40, 1'b1, 1'b1);
    nobr();
    step(); chk_pc("bcy_next", 32'h44, 1'b0, 1'b0);

    // registered V=0 would take bnv; forwarded V=1 must not
    fl(1'b1, 4'b0001);
    br(CC_BNV, 32'h300, 32'h0);
    step(); chk_pc("fwd_bnv", 32'h48, 1'b0, 1'b0);
    chk("fwd_bnv.flags", bus.flags, 32'h1);
    // registered V=1 would take bv; forwarded V=0 must not
    fl(1'b1, 4'b0000);
    br(CC_BV, 32'h300, 32'h0);
    step(); chk_pc("fwd_bv", 32'h4C, 1'b0, 1'b0);
    chk("fwd_bv.flags", bus.flags, 32'h0);

    fl(1'b0, 4'b0000);
    br(CC_BZ, 32'h80, 32'h0);
    step(); chk_pc("bz", 32'h80, 1'b1, 1'b1);
    br(CC_B, 32'h200, 32'h0);
    step(); chk_pc("flush_ign", 32'h84, 1'b0, 1'b0);
    br(CC_BNZ, 32'h100, 32'h5);
    step(); chk_pc("bnz", 32'h100, 1'b1, 1'b1);
    nobr();
    step(); chk_pc("bnz_next", 32'h104, 1'b0, 1'b0);
    br(CC_BZ, 32'h900, 32'h5);
    step(); chk_pc("bz_nt", 32'h108, 1'b0, 1'b0);
    br(CC_BLTZ, 32'h60, 32'h8000_0000);
    step(); chk_pc("bltz", 32'h60, 1'b1, 1'b1);
    nobr();
    step(); chk_pc("bltz_next", 32'h64, 1'b0, 1'b0);
    br(4'b1110, 32'h900, 32'h0);
    step(); chk_pc("reserved", 32'h68, 1'b0, 1'b0);
    br(CC_BR, 32'h900, 32'h1C);
    step(); chk_pc("br_alu", 32'h1C, 1'b1, 1'b1);
    nobr();
    step(); chk_pc("br_next", 32'h20, 1'b0, 1'b0);

    br(CC_CALL, 32'h80, 32'h0);
    step(); chk_pc("call", 32'h80, 1'b1, 1'b1);
    chk("call.lv", bus.link_valid, 32'h1);
    chk("call.la", bus.link_addr, 32'h24);
    nobr();
    bus.en = 1'b0;
    step(); chk_pc("stall1", 32'h80, 1'b0, 1'b1);
    chk("stall1.lv", bus.link_valid, 32'h0);
    chk("stall1.la", bus.link_addr, 32'h24);
    step(); chk_pc("stall2", 32'h80, 1'b0, 1'b1);
    bus.en = 1'b1;
    step(); chk_pc("unstall", 32'h84, 1'b0, 1'b0);

    bus.en = 1'b0;
    fl(1'b1, 4'b1111);
    step(); chk_pc("stall_fl", 32'h84, 1'b0, 1'b0);
    chk("stall_fl.flags", bus.flags, 32'h0);
    bus.en = 1'b1;
    fl(1'b0, 4'b0000);

    br(CC_B, 32'h500, 32'h0);
    step(); chk_pc("b", 32'h500, 1'b1, 1'b1);
    rst = 1'b1;
    br(CC_B, 32'h700, 32'h0);
    fl(1'b1, 4'b1111);
    step(); chk_pc("rst_flush", 32'h0, 1'b0, 1'b0);
    chk("rst_flush.flags", bus.flags, 32'h0);
    chk("rst_flush.lv", bus.link_valid, 32'h0);
    chk("rst_flush.la", bus.link_addr, 32'h0);
    rst = 1'b0;
    nobr();
    fl(1'b0, 4'b0000);

    br(CC_B, 32'hFFFF_FFF8, 32'h0);
    step(); chk_pc("to_top", 32'hFFFF_FFF8, 1'b1, 1'b1);
    nobr();
    step(); chk_pc("top", 32'hFFFF_FFFC, 1'b0, 1'b0);
    step(); chk_pc("wrap", 32'h0, 1'b0, 1'b0);

    br(CC_BCY, 32'h900, 32'h0);
    step(); chk_pc("bcy_nt", 32'h4, 1'b0, 1'b0);
    br(CC_BNCY, 32'h40, 32'h0);
    step(); chk_pc("bncy", 32'h40, 1'b1, 1'b1);
    nobr();
    step(); chk_pc("bncy_next", 32'h44, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
